rsa_operand_loader: RTL and testbench
=====================================

# rsa_operand_loader

Upstream feeder for the RSA core. It accepts a narrow valid/ready word stream carrying one operand frame (message, exponent, modulus), deserialises it into the three 2048-bit operand buses, and issues the `ds` start strobe when the core reports `ready`. It then holds the operands stable until the core finishes, and signals completion before accepting the next frame.

## Interface
- `KEY_W`, 2048: operand width. Must be a multiple of `WORD_W`.
- `WORD_W`, 32: stream word width.
- `WPO` (derived), `KEY_W/WORD_W` = 64: words per operand. A frame is `3*WPO` = 192 words.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `s_data`  in  `WORD_W`: stream word.
- `s_valid`  in  1: `s_data` is valid.
- `s_last`  in  1: final word of the frame.
- `s_ready`  out  1: loader accepts a word this cycle.
- `indata`  out  `KEY_W`: message operand to the core.
- `inExp`  out  `KEY_W`: exponent operand to the core.
- `inMod`  out  `KEY_W`: modulus operand to the core.
- `ds`  out  1: start strobe to the core, one-cycle pulse.
- `ready`  in  1: core idle / result valid.
- `busy`  out  1: a frame is held or in flight (state is not LOAD).
- `done`  out  1: one-cycle pulse when the core returns to ready after `ds`.
- `frame_err`  out  1: one-cycle pulse on a malformed frame.

## Operation
- Frame order: words 0..63 go to `indata`, 64..127 to `inExp`, 128..191 to `inMod`. Within each operand, the first word is bits [31:0] and the last is [KEY_W-1:KEY_W-32] (little-endian words).
- A word is accepted when `s_valid & s_ready`. The counter `cnt` (0..191, width clog2(192)) increments only on acceptance. Gaps in `s_valid` are allowed.
- States:
  - LOAD: `s_ready` = 1. Accepting word 191 with `s_last`=1 → ARM.
  - ARM: operands complete. If `ready`=1, drive `ds`<=1 (registered) → WAIT_LO.
  - WAIT_LO: wait for `ready`=0 → WAIT_HI.
  - WAIT_HI: on `ready`=1, drive `done`<=1, clear `cnt` → LOAD.
- Error handling:
  - `s_last`=1 on a word with `cnt`<191: pulse `frame_err`, set `cnt`=0, stay in LOAD. Partial operand contents are don't-care and are overwritten by the next frame.
  - Word 191 accepted with `s_last`=0: same response (`frame_err`, `cnt`=0, stay in LOAD, no `ds`).
- Operand registers change only on accepted words in LOAD. They are stable from ARM until `done`.
- `ds` is never high outside the ARM→WAIT_LO transition cycle. It is never asserted while `ready`=0.

## Timing
- Reset values: `indata`/`inExp`/`inMod` = 0, `ds` = 0, `done` = 0, `frame_err` = 0, `busy` = 0, `cnt` = 0, state = LOAD. `s_ready` = 0 while `reset`=1 and 1 in the first cycle after.
- Last word accepted at cycle N: `s_ready`=0 and `busy`=1 from N+1. With `ready` already 1, `ds`=1 at N+2 for exactly one cycle.
- `frame_err` is high in the cycle after the offending acceptance. `s_ready` stays 1 throughout (no stall).
- `ready` rising seen in WAIT_HI at cycle M: `done`=1 at M+1, with `s_ready`=1 and `busy`=0 in the same cycle.
- Reset during any state (including WAIT_LO/WAIT_HI) returns everything to reset values next cycle. No `done` is issued for the aborted operation.

## Structure
- `rsa_pkg`: `KEY_W`, `WORD_W`, `WPO`, `FRAME_WORDS`, `ldr_state_t` enum {LOAD, ARM, WAIT_LO, WAIT_HI}.
- Sub-module `rsa_word_shifter` (parameters `KEY_W`, `WORD_W`): a shift register with enable that inserts each word at the MSB end and shifts down. After `WPO` shifts, the first word sits at [31:0]. Instantiate it three times, with enables decoded from `cnt` segment (cnt/64). This avoids a wide indexed-write mux.

## Test plan
- Reset: hold `reset` 3 cycles → all outputs 0, `s_ready`=0. First cycle after release: `s_ready`=1, `busy`=0.
- Nominal frame, word i = i, `ready`=1, `s_valid` random gaps → `indata[31:0]`=0, `indata[2047:2016]`=63, `inExp[31:0]`=64, `inMod[2047:2016]`=191. `ds` is a single pulse 2 cycles after the last acceptance.
- Core handshake: hold `ready`=0 for 10 cycles in ARM → no `ds` until `ready`=1. Then drop `ready` 3 cycles after `ds` and raise it 50 cycles later → `done` is one pulse, `s_ready`=1 in the same cycle, and the operands were unchanged throughout.
- Early `s_last` at word 100 → `frame_err` pulse and no `ds`. A following correct 192-word frame loads and fires normally.
- Word 191 with `s_last`=0 → `frame_err`, `busy` stays 0, no `ds`.
- Reset asserted in WAIT_HI → operands 0, `ds`/`done` stay 0, state LOAD with `s_ready`=1 after release.

Source files
------------

// File: rtl/rsa_operand_loader_pkg.sv
// Shared constants and the loader state type for the RSA operand loader.
package rsa_pkg;

  localparam int KEY_W       = 2048;
  localparam int WORD_W      = 32;
  localparam int WPO         = KEY_W / WORD_W;
  localparam int FRAME_WORDS = 3 * WPO;
  localparam int CNT_W       = $clog2(FRAME_WORDS);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    ARM     = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/rsa_operand_loader_if.sv
// Word-stream bundle feeding the operand loader (valid/ready with frame marker).
interface rsa_operand_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/rsa_operand_loader_word_shifter.sv
// Operand deserialiser: each enabled word enters at the MSB end and the
// register shifts down one word, so after WPO shifts the first word is at [WORD_W-1:0].
module rsa_word_shifter #(
  parameter int KEY_W  = 2048,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WORD_W-1:0] word,
  output logic [KEY_W-1:0]  data
);

  // Shift one word in from the top on each enable; clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (en) begin
      data <= {word, data[KEY_W-1:WORD_W]};
    end
  end

endmodule

// File: rtl/rsa_operand_loader.sv
// Collects one message/exponent/modulus frame from the word stream, starts the
// RSA core with a one-cycle ds strobe, and holds the operands until it finishes.
module rsa_operand_loader
  import rsa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  rsa_operand_loader_if.slave s,
  output logic [KEY_W-1:0]   indata,
  output logic [KEY_W-1:0]   inExp,
  output logic [KEY_W-1:0]   inMod,
  output logic               ds,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic               frame_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

  ldr_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ds_reg, ds_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic             load_ready;
  logic             accept;
  logic [CNT_W-1:0] seg;
  logic [KEY_W-1:0] op [3];

  // Ready is gated by reset so upstream sees no acceptance while reset is held.
  assign load_ready = (state_reg == LOAD) && !reset;
  assign s.s_ready  = load_ready;
  assign accept     = s.s_valid && load_ready;
  assign seg        = cnt_reg / CNT_W'(WPO);

  // One shifter per operand; the counter segment selects which one advances.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_op
      rsa_word_shifter #(
        .KEY_W  (KEY_W),
        .WORD_W (WORD_W)
      ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .en    (accept && (seg == CNT_W'(gi))),
        .word  (s.s_data),
        .data  (op[gi])
      );
    end
  endgenerate

  assign indata    = op[0];
  assign inExp     = op[1];
  assign inMod     = op[2];
  assign ds        = ds_reg;
  assign done      = done_reg;
  assign frame_err = err_reg;
  assign busy      = (state_reg != LOAD);

  // State, word counter and the registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= LOAD;
      cnt_reg   <= '0;
      ds_reg    <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ds_reg    <= ds_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic: a frame is good only if s_last coincides with word 191.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ds_next    = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      LOAD: begin
        if (accept) begin
          if (cnt_reg == LAST_CNT) begin
            if (s.s_last) begin
              state_next = ARM;
            end else begin
              err_next = 1'b1;
              cnt_next = '0;
            end
          end else if (s.s_last) begin
            err_next = 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ARM: begin
        if (ready) begin
          ds_next    = 1'b1;
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ready) state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (ready) begin
          done_next  = 1'b1;
          cnt_next   = '0;
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed bench for rsa_operand_loader: nominal load, core handshake,
// malformed frames and reset during an operation.
module tb_rsa_operand_loader;
  import rsa_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready = 1'b1;
  always #5 clk = ~clk;

  rsa_operand_loader_if #(.WORD_W(WORD_W)) bus ();

  logic [KEY_W-1:0] indata, inExp, inMod;
  logic             ds, busy, done, frame_err;

  rsa_operand_loader dut (
    .clk       (clk),
    .reset     (reset),
    .s         (bus.slave),
    .indata    (indata),
    .inExp     (inExp),
    .inMod     (inMod),
    .ds        (ds),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int ds_count = 0, done_count = 0, err_count = 0;
  int ds_cyc = -1, err_cyc = -1;
  logic done_sready = 1'b0, done_busy = 1'b1;
  logic [KEY_W-1:0] snap_d, snap_e, snap_m;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (ds) begin
      ds_count++;
      ds_cyc = cyc;
    end
    if (done) begin
      done_count++;
      done_sready = bus.s_ready;
      done_busy   = busy;
    end
    if (frame_err) begin
      err_count++;
      err_cyc = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int gap;
    int tries;
    gap = $urandom_range(0, 2);
    bus.s_valid = 1'b0;
    if (gap > 0) tick(gap);
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    tries = 0;
    while (!bus.s_ready && tries < 20) begin
      tick(1);
      tries++;
    end
    if (tries == 20) check_eq("accept_timeout", 64'(tries), 64'd0);
    @(posedge clk);
    #1;
    last_acc    = cyc;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n, input bit last_flag);
    for (int i = 0; i < n; i++) send_word(32'(base + i), last_flag && (i == n - 1));
  endtask

  // Complete the core handshake: ready low, then high again.
  task automatic finish_core();
    ready = 1'b0;
    tick(2);
    ready = 1'b1;
    tick(2);
  endtask

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;

    // Reset state
    tick(3);
    check_eq("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ds_done_err", {61'd0, ds, done, frame_err}, 64'd0);
    check_eq("rst_indata", indata[63:0], 64'd0);
    reset = 1'b0;
    tick(1);
    check_eq("rel_s_ready", 64'(bus.s_ready), 64'd1);
    check_eq("rel_busy", 64'(busy), 64'd0);

    // Nominal frame, word i = i
    send_frame(0, FRAME_WORDS, 1'b1);
    tick(1);
    check_eq("armed_s_ready", 64'(bus.s_ready), 64'd0);
    check_eq("armed_busy", 64'(busy), 64'd1);
    tick(4);
    check_eq("nom_ds_count", 64'(ds_count), 64'd1);
    check_eq("nom_ds_latency", 64'(ds_cyc - last_acc), 64'd1);
    check_eq("nom_indata_lo", 64'(indata[31:0]), 64'd0);
    check_eq("nom_indata_w1", 64'(indata[63:32]), 64'd1);
    check_eq("nom_indata_hi", 64'(indata[2047:2016]), 64'd63);
    check_eq("nom_inexp_lo", 64'(inExp[31:0]), 64'd64);
    check_eq("nom_inexp_hi", 64'(inExp[2047:2016]), 64'd127);
    check_eq("nom_inmod_lo", 64'(inMod[31:0]), 64'd128);
    check_eq("nom_inmod_hi", 64'(inMod[2047:2016]), 64'd191);
    finish_core();
    check_eq("nom_done_count", 64'(done_count), 64'd1);
    check_eq("nom_done_s_ready", 64'(done_sready), 64'd1);
    check_eq("nom_done_busy", 64'(done_busy), 64'd0);

    // Core handshake: ready low while armed
    ready = 1'b0;
    send_frame(2000, FRAME_WORDS, 1'b1);
    tick(10);
    check_eq("hs_no_ds", 64'(ds_count), 64'd1);
    check_eq("hs_busy", 64'(busy), 64'd1);
    snap_d = indata;
    snap_e = inExp;
    snap_m = inMod;
    ready = 1'b1;
    tick(1);
    check_eq("hs_ds_count", 64'(ds_count), 64'd2);
    tick(2);
    ready = 1'b0;
    tick(50);
    check_eq("hs_ds_single", 64'(ds_count), 64'd2);
    check_eq("hs_no_early_done", 64'(done_count), 64'd1);
    ready = 1'b1;
    tick(3);
    check_eq("hs_done_count", 64'(done_count), 64'd2);
    check_eq("hs_done_s_ready", 64'(done_sready), 64'd1);
    check_eq("hs_done_busy", 64'(done_busy), 64'd0);
    check_eq("hs_hold", {61'd0, indata == snap_d, inExp == snap_e, inMod == snap_m}, 64'd7);
    check_eq("hs_inmod_hi", 64'(inMod[2047:2016]), 64'd2191);

    // Early s_last on word 100
    send_frame(500, 101, 1'b1);
    tick(1);
    check_eq("early_err_count", 64'(err_count), 64'd1);
    check_eq("early_err_timing", 64'(err_cyc - last_acc), 64'd0);
    check_eq("early_s_ready", 64'(bus.s_ready), 64'd1);
    tick(5);
    check_eq("early_no_ds", 64'(ds_count), 64'd2);
    check_eq("early_busy", 64'(busy), 64'd0);

    // Recovery frame after the error
    send_frame(1000, FRAME_WORDS, 1'b1);
    tick(4);
    check_eq("rec_ds_count", 64'(ds_count), 64'd3);
    check_eq("rec_indata_lo", 64'(indata[31:0]), 64'd1000);
    check_eq("rec_inexp_lo", 64'(inExp[31:0]), 64'd1064);
    check_eq("rec_inmod_hi", 64'(inMod[2047:2016]), 64'd1191);
    finish_core();
    check_eq("rec_done_count", 64'(done_count), 64'd3);

    // Word 191 without s_last
    send_frame(0, FRAME_WORDS, 1'b0);
    tick(1);
    check_eq("nolast_err_count", 64'(err_count), 64'd2);
    check_eq("nolast_busy", 64'(busy), 64'd0);
    tick(5);
    check_eq("nolast_no_ds", 64'(ds_count), 64'd3);

    // Reset while waiting for the core to finish
    send_frame(7, FRAME_WORDS, 1'b1);
    tick(4);
    check_eq("abort_ds_count", 64'(ds_count), 64'd4);
    ready = 1'b0;
    tick(3);
    check_eq("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    tick(1);
    ready = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_eq("abort_s_ready", 64'(bus.s_ready), 64'd1);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_indata", indata[63:0], 64'd0);
    check_eq("abort_inmod_hi", 64'(inMod[2047:2016]), 64'd0);
    tick(5);
    check_eq("abort_ds_count_after", 64'(ds_count), 64'd4);
    check_eq("abort_no_done", 64'(done_count), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
